// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_pkg
//  Purpose  : Shared types and limits for the UART command assembler.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  // Assembler FSM: IDLE holds no partial bytes, ASSEMBLE holds 1..CMD_BYTES-1.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } state_t;

  // Widest command supported (bytes).
  localparam int CMD_BYTES_MAX = 8;

endpackage : uart_cmd_pkg
`default_nettype wire

// File: rtl/uart_cmd_assembler_timer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_timer
//  Purpose  : Inter-byte idle counter. Counts cycles while enabled and not
//             cleared; raises a one-cycle expire when the terminal count is
//             reached. A clear in the terminal cycle suppresses expire.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_timer #(
  parameter int TIMEOUT_CYC = 78125
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int              c_cnt_w = $clog2(TIMEOUT_CYC);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYC - 1);

  logic [c_cnt_w-1:0] r_count;

  assign expire = en && !clear && (r_count == c_last);

  // Idle counter: restarts on clear, advances while enabled, wraps at expiry.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= expire ? '0 : r_count + c_cnt_w'(1);
    end
  end

endmodule : uart_cmd_timer
`default_nettype wire

// File: rtl/uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_assembler
//  Purpose  : Acks bytes from the UART receiver and packs CMD_BYTES of them,
//             first byte in the MSBs, into one command word presented with a
//             cmd_rdy / clr_cmd_rdy level handshake. Flags overrun when a new
//             command overwrites an unconsumed one.
//  Config   : define UART_CMD_TIMEOUT_EN to discard partial commands after
//             TIMEOUT_CYC idle cycles between bytes (timeout_err pulse).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int CMD_BYTES   = 2,
  parameter int TIMEOUT_CYC = 78125
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_rdy,
  output logic                   clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int                 c_cmd_w   = 8 * CMD_BYTES;
  localparam int                 c_cnt_w   = $clog2(CMD_BYTES) + 1;
  localparam logic [c_cnt_w-1:0] c_last_bc = c_cnt_w'(CMD_BYTES - 1);

  // Elaboration guard against unsupported configurations.
  if (CMD_BYTES < 1 || CMD_BYTES > CMD_BYTES_MAX || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("uart_cmd_assembler: CMD_BYTES must be 1..8 and TIMEOUT_CYC >= 2");
  end

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_byte_cnt, w_byte_cnt_nxt;
  logic [c_cmd_w-1:0]   r_shift;
  logic [c_cmd_w-1:0]   r_cmd;
  logic                 r_cmd_rdy;
  logic                 r_overrun;
  logic [c_cmd_w+7:0]   w_shift_ext;
  logic                 w_capture;
  logic                 w_complete;
  logic                 w_timeout;

  // The receiver holds rdy until acked and drops it on the ack edge, so
  // every rdy cycle is a fresh byte.
  assign w_capture   = rx_rdy;
  assign clr_rx_rdy  = rx_rdy;
  assign w_complete  = w_capture && (r_byte_cnt == c_last_bc);
  // Older bytes fall off the top; the low c_cmd_w bits are the newest bytes.
  assign w_shift_ext = {r_shift, rx_data};

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;
  assign overrun = r_overrun;

`ifdef UART_CMD_TIMEOUT_EN
  logic w_timer_clear;
  logic w_timer_en;
  logic w_expire;
  logic r_timeout_err;

  assign w_timer_clear = w_capture || (r_state == IDLE);
  assign w_timer_en    = (r_state == ASSEMBLE);

  uart_cmd_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_timer_clear),
    .en     (w_timer_en),
    .expire (w_expire)
  );

  // Expire is already masked by a same-cycle capture inside the timer.
  assign w_timeout = w_expire;

  // One-cycle error pulse on the edge that discards the partial command.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_expire;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // FSM and byte counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  // Next state: capture advances or completes; timeout drops partial bytes.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    if (w_capture) begin
      if (w_complete) begin
        w_state_nxt    = IDLE;
        w_byte_cnt_nxt = '0;
      end else begin
        w_state_nxt    = ASSEMBLE;
        w_byte_cnt_nxt = r_byte_cnt + c_cnt_w'(1);
      end
    end else if (w_timeout) begin
      w_state_nxt    = IDLE;
      w_byte_cnt_nxt = '0;
    end
  end

  // Shift register collects bytes; completion loads the command word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cmd   <= '0;
    end else if (w_capture) begin
      r_shift <= w_shift_ext[c_cmd_w-1:0];
      if (w_complete) begin
        r_cmd <= w_shift_ext[c_cmd_w-1:0];
      end
    end
  end

  // Handshake flags: completion beats a same-cycle clear; overrun is sticky
  // until the consumer clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_rdy <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_complete) begin
        r_cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
      if (clr_cmd_rdy) begin
        r_overrun <= 1'b0;
      end else if (w_complete && r_cmd_rdy) begin
        r_overrun <= 1'b1;
      end
    end
  end

endmodule : uart_cmd_assembler
`default_nettype wire

// File: tb/tb_uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_assembler
//  Purpose  : Self-checking bench for uart_cmd_assembler (CMD_BYTES=2,
//             TIMEOUT_CYC=100). Table of two-byte commands plus hand-written
//             handshake, timeout and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_assembler;

  localparam int c_bytes   = 2;
  localparam int c_timeout = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        overrun;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] cmd;
    logic        rdy;
    logic        ovr;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          gap;
    logic        pre_clr;
    logic        same_clr;
    logic [15:0] exp_cmd;
    logic        exp_rdy;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[6];

  // Bench model of the presented handshake state.
  logic [15:0] m_cmd;
  logic        m_rdy;

  uart_cmd_assembler #(
    .CMD_BYTES   (c_bytes),
    .TIMEOUT_CYC (c_timeout)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drive one byte like the UART receiver; rdy drops just after the capture edge.
  task automatic send_byte(input logic [7:0] b, input logic clr);
    @(negedge clk);
    rx_data     = b;
    rx_rdy      = 1'b1;
    clr_cmd_rdy = clr;
    #1 check("clr_rx_rdy_follows_rdy", {31'd0, clr_rx_rdy}, 32'd1);
    @(posedge clk);
    #1;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

  // Final byte of a command: expectation pushed with the stimulus, popped after the edge.
  task automatic send_last(input logic [7:0] b, input logic clr, input exp_t e, input string tag);
    exp_t got;
    sb.push_back(e);
    send_byte(b, clr);
    got = sb.pop_front();
    check({tag, "_cmd"},     {16'd0, cmd},          {16'd0, got.cmd});
    check({tag, "_cmd_rdy"}, {31'd0, cmd_rdy},      {31'd0, got.rdy});
    check({tag, "_overrun"}, {31'd0, overrun},      {31'd0, got.ovr});
    m_cmd = got.cmd;
    m_rdy = got.rdy;
  endtask

  // Consumer ack pulse; cmd must hold, rdy and overrun must clear.
  task automatic clear_cmd(input string tag);
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    check({tag, "_clr_cmd_rdy"}, {31'd0, cmd_rdy}, 32'd0);
    check({tag, "_clr_overrun"}, {31'd0, overrun}, 32'd0);
    check({tag, "_clr_cmd_hold"}, {16'd0, cmd},    {16'd0, m_cmd});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd"},         {16'd0, cmd},         32'd0);
    check({tag, "_cmd_rdy"},     {31'd0, cmd_rdy},     32'd0);
    check({tag, "_overrun"},     {31'd0, overrun},     32'd0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    check({tag, "_clr_rx_rdy"},  {31'd0, clr_rx_rdy},  32'd0);
  endtask

  initial begin
    exp_t e;
    int   seen;
    int   hits;

    //           b0     b1     gap pre  same  cmd       rdy   ovr
    vecs[0] = '{8'hA5, 8'h3C, 0,  1'b0, 1'b0, 16'hA53C, 1'b1, 1'b0};
    vecs[1] = '{8'h11, 8'h22, 3,  1'b1, 1'b0, 16'h1122, 1'b1, 1'b0};
    vecs[2] = '{8'h33, 8'h44, 0,  1'b0, 1'b0, 16'h3344, 1'b1, 1'b1};
    vecs[3] = '{8'hBE, 8'hEF, 10, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 8'hFE, 50, 1'b1, 1'b0, 16'h01FE, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 8'h5A, 1,  1'b0, 1'b0, 16'h5A5A, 1'b1, 1'b1};

    rst         = 1'b1;
    rx_data     = 8'h00;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    m_cmd       = 16'h0000;
    m_rdy       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Table of two-byte commands with handshake variations.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre_clr) clear_cmd($sformatf("vec%0d_pre", i));
      send_byte(vecs[i].b0, 1'b0);
      check($sformatf("vec%0d_first_byte_cmd_hold", i), {16'd0, cmd}, {16'd0, m_cmd});
      check($sformatf("vec%0d_first_byte_rdy_hold", i), {31'd0, cmd_rdy}, {31'd0, m_rdy});
      repeat (vecs[i].gap) @(posedge clk);
      e = '{cmd: vecs[i].exp_cmd, rdy: vecs[i].exp_rdy, ovr: vecs[i].exp_ovr};
      send_last(vecs[i].b1, vecs[i].same_clr, e, $sformatf("vec%0d", i));
    end

    // Overrun is cleared by the consumer ack.
    clear_cmd("overrun_ack");

    // Inter-byte timeout behaviour.
    send_byte(8'h55, 1'b0);
`ifdef UART_CMD_TIMEOUT_EN
    seen = 0;
    for (int c = 1; c <= 3 * c_timeout; c++) begin
      @(posedge clk);
      #1;
      if (timeout_err === 1'b1) begin
        seen = c;
        break;
      end
    end
    check("timeout_pulse_cycle", seen, c_timeout);
    @(posedge clk);
    #1 check("timeout_pulse_width", {31'd0, timeout_err}, 32'd0);
    check("timeout_cmd_rdy_untouched", {31'd0, cmd_rdy}, 32'd0);
    send_byte(8'h66, 1'b0);
    e = '{cmd: 16'h6677, rdy: 1'b1, ovr: 1'b0};
    send_last(8'h77, 1'b0, e, "after_timeout");
`else
    hits = 0;
    for (int c = 0; c < c_timeout + 20; c++) begin
      @(posedge clk);
      #1;
      if (timeout_err !== 1'b0) hits++;
    end
    check("timeout_err_tied_low", hits, 0);
    e = '{cmd: 16'h5566, rdy: 1'b1, ovr: 1'b0};
    send_last(8'h66, 1'b0, e, "no_timeout");
`endif

    // Reset in the middle of a command drops the partial byte.
    send_byte(8'h99, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("mid_reset");
    m_cmd = 16'h0000;
    m_rdy = 1'b0;
    send_byte(8'h12, 1'b0);
    check("mid_reset_partial_no_rdy", {31'd0, cmd_rdy}, 32'd0);
    e = '{cmd: 16'h1234, rdy: 1'b1, ovr: 1'b0};
    send_last(8'h34, 1'b0, e, "after_reset");

    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_cmd_assembler
`default_nettype wire
